// File: rtl/mctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction
// type codes, ALU and flag-mask codes, and the ALU register-file write mask.
package mctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EX   = 3'b010,
        ST_MEM  = 3'b011,
        ST_WB   = 3'b100,
        ST_TRAP = 3'b111
    } state_e;

    localparam logic [2:0] TYPE_BRANCH = 3'b000;
    localparam logic [2:0] TYPE_ALU    = 3'b001;
    localparam logic [2:0] TYPE_CONST  = 3'b010;
    localparam logic [2:0] TYPE_MEM    = 3'b100;
    localparam logic [2:0] TYPE_JUMP   = 3'b110;

    localparam logic [4:0] ALU_ONES  = 5'b11111;
    localparam logic [4:0] ALU_PASSB = 5'b10011;
    localparam logic [4:0] ALU_ZEROS = 5'b10000;

    localparam logic [2:0] TF_NONE = 3'b111;
    localparam logic [2:0] TF_JAL  = 3'b011;

    localparam logic [1:0] MXRB_PC  = 2'b00;
    localparam logic [1:0] MXRB_MEM = 2'b01;
    localparam logic [1:0] MXRB_ALU = 2'b10;

    localparam logic [2:0] RF_NONE = 3'b000;

    // Register-file write mask for an ALU instruction, keyed on op[4:0].
    function automatic logic [2:0] alu_rf_mask(input logic [4:0] op5);
        logic [2:0] mask;
        if (op5 == ALU_ONES || op5 == ALU_PASSB) begin
            mask = RF_NONE;
        end else if (op5 == ALU_ZEROS) begin
            mask = 3'b001;
        end else if (op5[4:3] == 2'b01) begin
            mask = 3'b011;
        end else if (op5[4:3] == 2'b00) begin
            mask = 3'b100;
        end else begin
            mask = 3'b010;
        end
        return mask;
    endfunction

endpackage

// File: rtl/mctrl_decode.sv
// Combinational instruction decode: type/op fields to the datapath control
// bundle that the FSM latches in ID. Illegal types decode as a NOP.
module mctrl_decode
    import mctrl_pkg::*;
#(
    parameter int OPW   = 5,
    parameter int TYPEW = 3
) (
    input  logic [TYPEW-1:0] type_i,
    input  logic [OPW-1:0]   op_i,
    output logic [OPW-1:0]   op_alu,
    output logic [2:0]       op_tf,
    output logic             op_se,
    output logic             s_mxse,
    output logic [1:0]       s_mxrb,
    output logic [2:0]       w_rf,
    output logic             w_rb,
    output logic             store,
    output logic             is_mem,
    output logic             illegal
);

    logic upper_nz;

    generate
        if (TYPEW > 3) begin : g_upper
            assign upper_nz = |type_i[TYPEW-1:3];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        op_alu  = '0;
        op_tf   = TF_NONE;
        op_se   = 1'b0;
        s_mxse  = 1'b0;
        s_mxrb  = MXRB_PC;
        w_rf    = RF_NONE;
        w_rb    = 1'b0;
        store   = 1'b0;
        is_mem  = 1'b0;
        illegal = 1'b0;
        if (upper_nz) begin
            illegal = 1'b1;
        end else begin
            case (type_i[2:0])
                TYPE_ALU: begin
                    op_alu = op_i;
                    w_rb   = 1'b1;
                    s_mxrb = MXRB_ALU;
                    w_rf   = alu_rf_mask(op_i[4:0]);
                end
                TYPE_CONST: begin
                    op_alu = op_i;
                    op_se  = 1'b1;
                    s_mxse = 1'b1;
                    w_rb   = 1'b1;
                    s_mxrb = MXRB_ALU;
                end
                TYPE_MEM: begin
                    is_mem = 1'b1;
                    if (op_i[0]) begin
                        store = 1'b1;
                    end else begin
                        w_rb   = 1'b1;
                        s_mxrb = MXRB_MEM;
                    end
                end
                TYPE_BRANCH: begin
                    op_alu = OPW'(ALU_PASSB);
                    op_tf  = op_i[2:0];
                    s_mxse = 1'b1;
                end
                TYPE_JUMP: begin
                    op_alu = OPW'(ALU_PASSB);
                    op_tf  = op_i[2:0];
                    w_rb   = (op_i[2:0] == TF_JAL);
                    s_mxrb = MXRB_PC;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: IF/ID/EX/MEM/WB sequencing, decode registers and the
// data-memory wait counter. MCTRL_ILLEGAL_TRAP_EN enables the illegal-type TRAP state.
// The instruction-class input is named TYPE because "type" is a reserved word.
module multicycle_control
    import mctrl_pkg::*;
#(
    parameter int OPW         = 5,
    parameter int TYPEW       = 3,
    parameter int DM_WAIT_MAX = 15
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IM_ACK,
    input  logic             DM_ACK,
    input  logic [TYPEW-1:0] TYPE,
    input  logic [OPW-1:0]   op,
    output logic [OPW-1:0]   OP_ALU,
    output logic [2:0]       OP_TF,
    output logic             OP_SE,
    output logic             S_MXSE,
    output logic [1:0]       S_MXRB,
    output logic             W_PC,
    output logic             W_IM,
    output logic             W_DM,
    output logic             W_RB,
    output logic [2:0]       W_RF,
    output logic             DM_REQ,
    output logic             DM_ERR,
    output logic             TRAP,
    output logic [2:0]       STATE_O
);

    localparam int CNTW = (DM_WAIT_MAX > 0) ? $clog2(DM_WAIT_MAX + 1) : 1;

    state_e           state_q, state_d;
    logic [OPW-1:0]   op_alu_q, op_alu_d;
    logic [2:0]       op_tf_q, op_tf_d;
    logic             op_se_q, op_se_d;
    logic             s_mxse_q, s_mxse_d;
    logic [1:0]       s_mxrb_q, s_mxrb_d;
    logic [2:0]       w_rf_q, w_rf_d;
    logic             w_rb_q, w_rb_d;
    logic             store_q, store_d;
    logic             is_mem_q, is_mem_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [OPW-1:0]   dec_op_alu;
    logic [2:0]       dec_op_tf;
    logic             dec_op_se;
    logic             dec_s_mxse;
    logic [1:0]       dec_s_mxrb;
    logic [2:0]       dec_w_rf;
    logic             dec_w_rb;
    logic             dec_store;
    logic             dec_is_mem;
    logic             dec_illegal;
    logic             dm_timeout;

    mctrl_decode #(
        .OPW   (OPW),
        .TYPEW (TYPEW)
    ) u_decode (
        .type_i  (TYPE),
        .op_i    (op),
        .op_alu  (dec_op_alu),
        .op_tf   (dec_op_tf),
        .op_se   (dec_op_se),
        .s_mxse  (dec_s_mxse),
        .s_mxrb  (dec_s_mxrb),
        .w_rf    (dec_w_rf),
        .w_rb    (dec_w_rb),
        .store   (dec_store),
        .is_mem  (dec_is_mem),
        .illegal (dec_illegal)
    );

    // A timeout needs the full wait budget spent with no acknowledge this cycle.
    assign dm_timeout = (state_q == ST_MEM) && !DM_ACK && (DM_WAIT_MAX != 0)
                        && (cnt_q == CNTW'(DM_WAIT_MAX));

    always_comb begin
        state_d  = state_q;
        op_alu_d = op_alu_q;
        op_tf_d  = op_tf_q;
        op_se_d  = op_se_q;
        s_mxse_d = s_mxse_q;
        s_mxrb_d = s_mxrb_q;
        w_rf_d   = w_rf_q;
        w_rb_d   = w_rb_q;
        store_d  = store_q;
        is_mem_d = is_mem_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IF: begin
                if (IM_ACK) begin
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                op_alu_d = dec_op_alu;
                op_tf_d  = dec_op_tf;
                op_se_d  = dec_op_se;
                s_mxse_d = dec_s_mxse;
                s_mxrb_d = dec_s_mxrb;
                w_rf_d   = dec_w_rf;
                w_rb_d   = dec_w_rb;
                store_d  = dec_store;
                is_mem_d = dec_is_mem;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                state_d  = dec_illegal ? ST_TRAP : ST_EX;
`else
                state_d  = ST_EX;
`endif
            end
            ST_EX: begin
                cnt_d   = '0;
                state_d = is_mem_q ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (DM_ACK) begin
                    state_d = ST_WB;
                end else if (dm_timeout) begin
                    // Aborted access: nothing valid to write back.
                    w_rb_d  = 1'b0;
                    state_d = ST_WB;
                end else begin
                    // Wraps harmlessly when the timeout is disabled.
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_WB:   state_d = ST_IF;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IF;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IF;
            op_alu_q <= '0;
            op_tf_q  <= TF_NONE;
            op_se_q  <= 1'b0;
            s_mxse_q <= 1'b0;
            s_mxrb_q <= MXRB_PC;
            w_rf_q   <= RF_NONE;
            w_rb_q   <= 1'b0;
            store_q  <= 1'b0;
            is_mem_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_alu_q <= op_alu_d;
            op_tf_q  <= op_tf_d;
            op_se_q  <= op_se_d;
            s_mxse_q <= s_mxse_d;
            s_mxrb_q <= s_mxrb_d;
            w_rf_q   <= w_rf_d;
            w_rb_q   <= w_rb_d;
            store_q  <= store_d;
            is_mem_q <= is_mem_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        OP_ALU = '0;
        OP_TF  = TF_NONE;
        OP_SE  = 1'b0;
        S_MXSE = 1'b0;
        S_MXRB = MXRB_PC;
        W_PC   = 1'b0;
        W_IM   = 1'b0;
        W_DM   = 1'b0;
        W_RB   = 1'b0;
        W_RF   = RF_NONE;
        DM_REQ = 1'b0;
        DM_ERR = 1'b0;
        case (state_q)
            // The fetch strobe follows IM_ACK but stays low while reset is held.
            ST_IF:   W_IM = IM_ACK & RESET_N;
            ST_EX: begin
                OP_ALU = op_alu_q;
                OP_TF  = op_tf_q;
                OP_SE  = op_se_q;
                S_MXSE = s_mxse_q;
            end
            ST_MEM: begin
                DM_REQ = 1'b1;
                W_DM   = store_q;
                DM_ERR = dm_timeout;
            end
            ST_WB: begin
                S_MXRB = s_mxrb_q;
                W_RF   = w_rf_q;
                W_RB   = w_rb_q;
                W_PC   = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MCTRL_ILLEGAL_TRAP_EN
    assign TRAP = (state_q == ST_TRAP);
`else
    logic illegal_unused;
    assign illegal_unused = dec_illegal;
    assign TRAP = 1'b0;
`endif

    assign STATE_O = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios followed by
// random instructions, each cycle compared against a per-instruction timeline model.
module tb_multicycle_control;

    localparam int MAXW = 3;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       IM_ACK = 1'b0;
    logic       DM_ACK = 1'b0;
    logic [2:0] TYPE = 3'b000;
    logic [4:0] op = 5'b00000;
    logic [4:0] OP_ALU;
    logic [2:0] OP_TF;
    logic       OP_SE, S_MXSE;
    logic [1:0] S_MXRB;
    logic       W_PC, W_IM, W_DM, W_RB;
    logic [2:0] W_RF;
    logic       DM_REQ, DM_ERR, TRAP;
    logic [2:0] STATE_O;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    multicycle_control #(
        .OPW         (5),
        .TYPEW       (3),
        .DM_WAIT_MAX (MAXW)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .IM_ACK  (IM_ACK),
        .DM_ACK  (DM_ACK),
        .TYPE    (TYPE),
        .op      (op),
        .OP_ALU  (OP_ALU),
        .OP_TF   (OP_TF),
        .OP_SE   (OP_SE),
        .S_MXSE  (S_MXSE),
        .S_MXRB  (S_MXRB),
        .W_PC    (W_PC),
        .W_IM    (W_IM),
        .W_DM    (W_DM),
        .W_RB    (W_RB),
        .W_RF    (W_RF),
        .DM_REQ  (DM_REQ),
        .DM_ERR  (DM_ERR),
        .TRAP    (TRAP),
        .STATE_O (STATE_O)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [4:0] alu;
        logic [2:0] tf;
        logic       se;
        logic       mxse;
        logic [1:0] mxrb;
        logic       pc;
        logic       im;
        logic       dm;
        logic       rb;
        logic [2:0] rf;
        logic       req;
        logic       err;
        logic       trap;
    } out_t;

    typedef struct packed {
        logic [4:0] alu;
        logic [2:0] tf;
        logic       se;
        logic       mxse;
        logic [1:0] mxrb;
        logic [2:0] rf;
        logic       rb;
        logic       store;
        logic       mem;
        logic       illegal;
    } dec_t;

    // Expected controls of one instruction, straight from the decode table.
    function automatic dec_t model(input logic [2:0] t, input logic [4:0] o);
        dec_t d;
        d = '0;
        d.tf = 3'b111;
        case (t)
            3'd1: begin
                d.alu = o; d.rb = 1'b1; d.mxrb = 2'd2;
                if (o == 5'd31 || o == 5'd19) d.rf = 3'd0;
                else if (o == 5'd16)          d.rf = 3'd1;
                else if (o[4:3] == 2'b01)     d.rf = 3'd3;
                else if (o[4:3] == 2'b00)     d.rf = 3'd4;
                else                          d.rf = 3'd2;
            end
            3'd2: begin
                d.alu = o; d.se = 1'b1; d.mxse = 1'b1; d.rb = 1'b1; d.mxrb = 2'd2;
            end
            3'd4: begin
                d.mem = 1'b1;
                if (o[0]) d.store = 1'b1;
                else begin d.rb = 1'b1; d.mxrb = 2'd1; end
            end
            3'd0: begin
                d.alu = 5'd19; d.tf = o[2:0]; d.mxse = 1'b1;
            end
            3'd6: begin
                d.alu = 5'd19; d.tf = o[2:0]; d.rb = (o[2:0] == 3'd3);
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    function automatic out_t idle(input logic [2:0] st);
        out_t e;
        e = '0;
        e.st = st;
        e.tf = 3'b111;
        return e;
    endfunction

    function automatic out_t sample();
        out_t s;
        s.st = STATE_O; s.alu = OP_ALU; s.tf = OP_TF; s.se = OP_SE; s.mxse = S_MXSE;
        s.mxrb = S_MXRB; s.pc = W_PC; s.im = W_IM; s.dm = W_DM; s.rb = W_RB;
        s.rf = W_RF; s.req = DM_REQ; s.err = DM_ERR; s.trap = TRAP;
        return s;
    endfunction

    task automatic check(input string tag, input out_t exp);
        out_t obs;
        obs = sample();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        TYPE = 3'($urandom);
        op   = 5'($urandom);
    endtask

    // One instruction: if_wait IM_ACK=0 cycles, mem_wait DM_ACK=0 cycles
    // (mem_wait > MAXW means the acknowledge never comes).
    task automatic run_instr(input logic [2:0] t, input logic [4:0] o, input int if_wait,
                             input int mem_wait, input bit rst_mid);
        dec_t d;
        out_t e;
        bit   tmo;
        d = model(t, o);
        $display("instr type=%0d op=%b if_wait=%0d mem_wait=%0d rst_mid=%0d",
                 t, o, if_wait, mem_wait, rst_mid);
        for (int i = 0; i <= if_wait; i++) begin
            @(negedge CLK);
            IM_ACK = (i == if_wait);
            DM_ACK = 1'($urandom);
            scramble();
            #1;
            e = idle(3'd0);
            e.im = IM_ACK;
            check("if", e);
        end
        @(negedge CLK);
        IM_ACK = 1'($urandom);
        TYPE = t;
        op = o;
        #1 check("id", idle(3'd1));
`ifdef MCTRL_ILLEGAL_TRAP_EN
        if (d.illegal) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge CLK);
                scramble();
                IM_ACK = 1'($urandom);
                #1;
                e = idle(3'd7);
                e.trap = 1'b1;
                check("trap", e);
            end
            @(negedge CLK);
            RESET_N = 1'b0;
            IM_ACK = 1'b0;
            #1 check("trap_rst", idle(3'd0));
            @(negedge CLK);
            RESET_N = 1'b1;
            return;
        end
`endif
        @(negedge CLK);
        scramble();
        #1;
        e = idle(3'd2);
        e.alu = d.alu; e.tf = d.tf; e.se = d.se; e.mxse = d.mxse;
        check("ex", e);
        tmo = 1'b0;
        if (d.mem) begin
            for (int k = 0; k <= MAXW; k++) begin
                @(negedge CLK);
                DM_ACK = (k == mem_wait);
                scramble();
                #1;
                tmo = !DM_ACK && (k == MAXW);
                e = idle(3'd3);
                e.req = 1'b1; e.dm = d.store; e.err = tmo;
                check("mem", e);
                if (rst_mid) begin
                    #2 RESET_N = 1'b0;
                    #1 check("rst_async", idle(3'd0));
                    @(negedge CLK);
                    IM_ACK = 1'b1;
                    #1 check("rst_hold", idle(3'd0));
                    IM_ACK = 1'b0;
                    RESET_N = 1'b1;
                    return;
                end
                if (DM_ACK || tmo) break;
            end
        end
        @(negedge CLK);
        DM_ACK = 1'($urandom);
        #1;
        e = idle(3'd4);
        e.pc = 1'b1; e.mxrb = d.mxrb; e.rf = d.rf; e.rb = d.rb && !tmo;
        check("wb", e);
    endtask

    initial begin
        IM_ACK = 1'b1;
        #2 check("reset", idle(3'd0));
        @(negedge CLK);
        #1 check("reset_hold", idle(3'd0));
        IM_ACK = 1'b0;
        RESET_N = 1'b1;

        run_instr(3'd1, 5'b00001, 0, 0, 1'b0);    // ALU add
        run_instr(3'd4, 5'b00000, 1, 3, 1'b0);    // load, ack on the last allowed cycle
        run_instr(3'd4, 5'b00001, 0, 99, 1'b0);   // store timeout
        run_instr(3'd6, 5'b00011, 0, 0, 1'b0);    // jal
        run_instr(3'd6, 5'b00010, 0, 0, 1'b0);    // jump without link
        run_instr(3'd5, 5'b01010, 0, 0, 1'b0);    // illegal type
        run_instr(3'd4, 5'b00000, 0, 99, 1'b1);   // reset mid-MEM
        run_instr(3'd1, 5'b10000, 2, 0, 1'b0);
        run_instr(3'd1, 5'b11111, 0, 0, 1'b0);
        run_instr(3'd1, 5'b10011, 0, 0, 1'b0);
        run_instr(3'd1, 5'b01101, 0, 0, 1'b0);
        run_instr(3'd1, 5'b11001, 0, 0, 1'b0);
        run_instr(3'd2, 5'b01100, 0, 0, 1'b0);
        run_instr(3'd0, 5'b00101, 0, 0, 1'b0);

        for (int n = 0; n < 120; n++) begin
            logic [2:0] t;
            t = 3'($urandom_range(0, 7));
            run_instr(t, 5'($urandom), $urandom_range(0, 2), $urandom_range(0, MAXW + 1),
                      (t == 3'd4) && ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
